// File: rtl/dmem_pkg.sv
// Shared types and sizes for the block-addressed data memory.
package dmem_pkg;
    localparam int DMEM_ADDR_W = 6;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 64;
    localparam int DMEM_LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;
endpackage

// File: rtl/dmem_latency_ctr.sv
// Load/decrement down-counter timing one memory access; zero flags expiry.
// Holds at zero rather than wrapping.
module dmem_latency_ctr
    import dmem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DMEM_LAT_W-1:0] i_load_val,
    input  logic                  i_dec,
    output logic                  zero
);
    logic [DMEM_LAT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DMEM_LAT_W'(1);
        end
    end

    assign zero = (r_count == '0);
endmodule

// File: rtl/dmem_block.sv
// 64 x 32-bit block memory behind a read/write/busywait handshake with a fixed LATENCY-cycle access.
// Optional DMEM_PROTOCOL_CHECK_EN adds a sticky proto_err flag for handshake violations.
module dmem_block
    import dmem_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [DMEM_ADDR_W-1:0] mem_address,
    input  logic [DMEM_DATA_W-1:0] mem_writedata,
    output logic [DMEM_DATA_W-1:0] mem_readdata,
    output logic                   mem_busywait
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    output logic                   proto_err
`endif
);
    localparam logic [DMEM_LAT_W-1:0] LP_LOAD = DMEM_LAT_W'(LATENCY - 1);

    dmem_state_t            r_state;
    logic                   r_op_wr;
    logic [DMEM_ADDR_W-1:0] r_addr;
    logic [DMEM_DATA_W-1:0] r_wdata;
    logic [DMEM_DATA_W-1:0] r_rdata;
    logic [DMEM_DATA_W-1:0] r_mem [DMEM_DEPTH];

    logic w_accept;
    logic w_zero;
    logic w_finish;

    // Simultaneous read and write is a cache bug; refuse it rather than guess.
    assign w_accept = (r_state == IDLE) && (mem_read ^ mem_write);
    assign w_finish = (r_state == BUSY) && w_zero;

    dmem_latency_ctr u_ctr (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (LP_LOAD),
        .i_dec      (r_state == BUSY),
        .zero       (w_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_wr <= mem_write;
                        r_addr  <= mem_address;
                        r_wdata <= mem_writedata;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_zero) begin
                        if (!r_op_wr) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_finish && r_op_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign mem_readdata = r_rdata;
    assign mem_busywait = !reset && (w_accept || (r_state == BUSY));

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic r_proto_err;
    logic w_both;
    logic w_drop;

    assign w_both = (r_state == IDLE) && mem_read && mem_write;
    assign w_drop = (r_state == BUSY) && (r_op_wr ? !mem_write : !mem_read);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_both || w_drop) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`endif
endmodule

// File: tb/tb_dmem_block.sv
// Bench for dmem_block: three instances (LATENCY 5, 1, 15) checked each cycle against a
// transaction-timestamp model, plus directed accesses with literal expectations.
module tb_dmem_block;
    logic        clock;
    logic        reset;
    logic        rd   [3];
    logic        wr   [3];
    logic [5:0]  addr [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        busy [3];
`ifdef DMEM_PROTOCOL_CHECK_EN
    logic        pe   [3];
`endif

    int checks = 0;
    int errors = 0;

    dmem_block #(.LATENCY(5)) u_dut0 (
        .clock(clock), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_address(addr[0]), .mem_writedata(wdat[0]),
        .mem_readdata(rdat[0]), .mem_busywait(busy[0])
`ifdef DMEM_PROTOCOL_CHECK_EN
        , .proto_err(pe[0])
`endif
    );
    dmem_block #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_address(addr[1]), .mem_writedata(wdat[1]),
        .mem_readdata(rdat[1]), .mem_busywait(busy[1])
`ifdef DMEM_PROTOCOL_CHECK_EN
        , .proto_err(pe[1])
`endif
    );
    dmem_block #(.LATENCY(15)) u_dut2 (
        .clock(clock), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]),
        .mem_address(addr[2]), .mem_writedata(wdat[2]),
        .mem_readdata(rdat[2]), .mem_busywait(busy[2])
`ifdef DMEM_PROTOCOL_CHECK_EN
        , .proto_err(pe[2])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lat_of(input int i);
        return (i == 0) ? 5 : ((i == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes LATENCY edges later, then one idle-handshake cycle.
    bit          m_act   [3];
    bit          m_done  [3];
    bit          m_wr    [3];
    bit          m_pe    [3];
    int          m_tdone [3];
    logic [5:0]  m_a     [3];
    logic [31:0] m_d     [3];
    logic [31:0] m_rdata [3];
    logic [31:0] m_mem   [3][64];
    int          cyc = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] = 0; m_done[i] = 0; m_wr[i] = 0; m_pe[i] = 0;
                m_tdone[i] = 0; m_rdata[i] = '0;
                for (int j = 0; j < 64; j++) m_mem[i][j] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (m_act[i] && (m_wr[i] ? !wr[i] : !rd[i])) m_pe[i] = 1;
                if (m_done[i]) begin
                    m_done[i] = 0;
                end else if (m_act[i]) begin
                    if (cyc == m_tdone[i]) begin
                        if (m_wr[i]) m_mem[i][m_a[i]] = m_d[i];
                        else         m_rdata[i] = m_mem[i][m_a[i]];
                        m_act[i]  = 0;
                        m_done[i] = 1;
                    end
                end else if (rd[i] ^ wr[i]) begin
                    m_act[i]   = 1;
                    m_tdone[i] = cyc + lat_of(i);
                    m_wr[i]    = wr[i];
                    m_a[i]     = addr[i];
                    m_d[i]     = wdat[i];
                end else if (rd[i] && wr[i]) begin
                    m_pe[i] = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            logic exp_busy;
            exp_busy = !reset && (m_act[i] || (!m_done[i] && (rd[i] ^ wr[i])));
            chk("busywait", i, {31'b0, busy[i]}, {31'b0, exp_busy});
            chk("readdata", i, rdat[i], m_rdata[i]);
`ifdef DMEM_PROTOCOL_CHECK_EN
            chk("proto_err", i, {31'b0, pe[i]}, {31'b0, m_pe[i]});
`endif
        end
    end

    // Counts busywait-high cycles after acceptance; returns data seen in the DONE cycle.
    task automatic count_busy(input int i, output int nb, output logic [31:0] rv);
        bit fin;
        nb  = 0;
        fin = 0;
        rv  = '0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clock);
            if (busy[i]) nb++;
            else begin
                fin = 1;
                rv  = rdat[i];
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout inst%0d busywait never dropped", i);
        end
    endtask

    // Called just after a rising edge; returns just after the edge leaving DONE.
    task automatic access(input int i, input bit w, input logic [5:0] a, input logic [31:0] d,
                          output int nb, output logic [31:0] rv);
        addr[i] = a;
        wdat[i] = d;
        if (w) wr[i] = 1'b1;
        else   rd[i] = 1'b1;
        @(negedge clock);
        count_busy(i, nb, rv);
        @(posedge clock);
        #1;
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    int          nb;
    logic [31:0] rv;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0; wr[i] = 0; addr[i] = '0; wdat[i] = '0;
        end
        @(posedge clock); #1;
        rd[0] = 1'b1;
        @(negedge clock);
        chk("reset_busywait_forced", 0, {31'b0, busy[0]}, 32'd0);
        chk("reset_readdata", 0, rdat[0], 32'h0);
        @(posedge clock); #1;
        rd[0] = 1'b0;
        reset = 1'b0;

        access(0, 0, 6'h00, 32'h0, nb, rv);
        chk("rd_after_reset_lat", 0, nb, 32'd5);
        chk("rd_after_reset_data", 0, rv, 32'h0000_0000);

        access(0, 1, 6'h2A, 32'hDEAD_BEEF, nb, rv);
        chk("wr_lat", 0, nb, 32'd5);
        chk("wr_keeps_readdata", 0, rv, 32'h0000_0000);
        access(0, 0, 6'h2A, 32'h0, nb, rv);
        chk("rd_lat", 0, nb, 32'd5);
        chk("rd_data", 0, rv, 32'hDEAD_BEEF);

        // Write request dropped one cycle after acceptance still commits.
        addr[0] = 6'h3F; wdat[0] = 32'hA5A5_A5A5; wr[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        wr[0] = 1'b0;
        count_busy(0, nb, rv);
        chk("drop_busy_remaining", 0, nb, 32'd4);
        @(posedge clock); #1;
        access(0, 0, 6'h3F, 32'h0, nb, rv);
        chk("drop_commit_data", 0, rv, 32'hA5A5_A5A5);

        // Reset two cycles into a write discards it and clears the array.
        addr[0] = 6'h05; wdat[0] = 32'h1234_5678; wr[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midwrite_reset_busywait", 0, {31'b0, busy[0]}, 32'd0);
        @(posedge clock); #1;
        wr[0] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        access(0, 0, 6'h05, 32'h0, nb, rv);
        chk("midwrite_reset_data", 0, rv, 32'h0000_0000);
        access(0, 0, 6'h2A, 32'h0, nb, rv);
        chk("array_cleared", 0, rv, 32'h0000_0000);

`ifdef DMEM_PROTOCOL_CHECK_EN
        rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 6'h01;
        @(negedge clock);
        chk("both_req_busywait", 1, {31'b0, busy[1]}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("both_req_proto_err", 1, {31'b0, pe[1]}, 32'd1);
        @(posedge clock); #1;
        rd[1] = 1'b0; wr[1] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("proto_err_sticky", 1, {31'b0, pe[1]}, 32'd1);
        @(posedge clock); #1;
`endif

        access(1, 1, 6'h01, 32'h1111_1111, nb, rv);
        access(1, 1, 6'h02, 32'h2222_2222, nb, rv);
        access(1, 0, 6'h01, 32'h0, nb, rv);
        chk("lat1_rd1_busy", 1, nb, 32'd1);
        chk("lat1_rd1_data", 1, rv, 32'h1111_1111);
        access(1, 0, 6'h02, 32'h0, nb, rv);
        chk("lat1_rd2_busy", 1, nb, 32'd1);
        chk("lat1_rd2_data", 1, rv, 32'h2222_2222);

        access(2, 1, 6'h10, 32'hCAFE_F00D, nb, rv);
        chk("lat15_wr_busy", 2, nb, 32'd15);
        access(2, 0, 6'h10, 32'h0, nb, rv);
        chk("lat15_rd_busy", 2, nb, 32'd15);
        chk("lat15_rd_data", 2, rv, 32'hCAFE_F00D);

`ifdef DMEM_PROTOCOL_CHECK_EN
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("proto_err_cleared", 1, {31'b0, pe[1]}, 32'd0);
`endif

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
